// File: rtl/seg7_pkg.sv
// Shared BCD digit type, active-low 7-segment glyphs ({g,f,e,d,c,b,a}) and decode helper
// for the BCD scan counter.
package seg7_pkg;

    typedef logic [3:0] bcd_t;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam bcd_t BCD_MAX = 4'd9;

    function automatic logic [6:0] seg_decode(input bcd_t d);
        logic [6:0] s;
        case (d)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // Width of the scan index; never below one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bcd_scan_counter_if.sv
// Control inputs and display/count outputs of the BCD scan counter, bundled with
// master (switches/buttons side) and slave (counter side) modports.
interface bcd_scan_counter_if #(
    parameter int NUM_DIGITS = 4
);
    import seg7_pkg::*;

    localparam int YW = idx_width(NUM_DIGITS);

    logic                      counten;
    logic                      up;
    logic                      clear;
    logic [4*NUM_DIGITS-1:0]   value;
    logic                      wrap;
    logic [YW-1:0]             Y;
    logic [NUM_DIGITS-1:0]     an;
    logic [6:0]                seg;

    modport master (
        output counten, up, clear,
        input  value, wrap, Y, an, seg
    );

    modport slave (
        input  counten, up, clear,
        output value, wrap, Y, an, seg
    );

endinterface

// File: rtl/bcd_digit.sv
// One BCD decade: increments with carry-out at 9, decrements with borrow-out at 0,
// synchronous clear has priority.
module bcd_digit
    import seg7_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic inc_i,
    input  logic dec_i,
    input  logic clr_i,
    output bcd_t digit_o,
    output logic carry_o,
    output logic borrow_o
);

    bcd_t digit_q;
    bcd_t digit_d;

    always_comb begin
        digit_d = digit_q;
        if (clr_i) begin
            digit_d = '0;
        end else if (inc_i) begin
            digit_d = (digit_q >= BCD_MAX) ? 4'd0 : digit_q + 4'd1;
        end else if (dec_i) begin
            digit_d = (digit_q == 4'd0) ? BCD_MAX : digit_q - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            digit_q <= '0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit_o  = digit_q;
    assign carry_o  = inc_i && (digit_q == BCD_MAX);
    assign borrow_o = dec_i && (digit_q == 4'd0);

endmodule

// File: rtl/bcd_scan_counter.sv
// N-digit BCD up/down counter with multiplexed active-low 7-segment scan outputs.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero digits above digit 0.
module bcd_scan_counter
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int COUNT_DIV   = 26,
    parameter int REFRESH_DIV = 17
) (
    input  logic                   clk,
    input  logic                   rst,
    bcd_scan_counter_if.slave      bus
);

    localparam int            YW     = idx_width(NUM_DIGITS);
    localparam logic [YW-1:0] Y_LAST = YW'(NUM_DIGITS - 1);

    logic [COUNT_DIV-1:0]   cpre_q, cpre_d;
    logic [REFRESH_DIV-1:0] rpre_q, rpre_d;
    logic [YW-1:0]          y_q, y_d;
    logic                   wrap_q, wrap_d;
    logic [NUM_DIGITS-1:0]  an_q, an_d;
    logic [6:0]             seg_q, seg_d;

    logic                   step;
    logic [NUM_DIGITS:0]    inc_c;
    logic [NUM_DIGITS:0]    dec_c;
    bcd_t                   digit_w [NUM_DIGITS];
    bcd_t                   cur_digit;
    logic                   blank;

    assign step     = bus.counten && (&cpre_q);
    assign inc_c[0] = step && bus.up;
    assign dec_c[0] = step && !bus.up;

    always_comb begin
        cpre_d = cpre_q;
        if (bus.clear) begin
            cpre_d = '0;
        end else if (bus.counten) begin
            cpre_d = cpre_q + COUNT_DIV'(1);
        end
    end

    // Each decade steps only when every lower decade rolls over.
    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
        bcd_digit u_digit (
            .clk      (clk),
            .rst      (rst),
            .inc_i    (inc_c[k]),
            .dec_i    (dec_c[k]),
            .clr_i    (bus.clear),
            .digit_o  (digit_w[k]),
            .carry_o  (inc_c[k+1]),
            .borrow_o (dec_c[k+1])
        );
    end

    assign wrap_d = (inc_c[NUM_DIGITS] || dec_c[NUM_DIGITS]) && !bus.clear;

    always_comb begin
        bus.value = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            bus.value[4*k +: 4] = digit_w[k];
        end
    end

    always_comb begin
        rpre_d = rpre_q + REFRESH_DIV'(1);
        y_d    = y_q;
        if (&rpre_q) begin
            y_d = (y_q >= Y_LAST) ? '0 : y_q + YW'(1);
        end
    end

    always_comb begin
        cur_digit = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (y_q == YW'(k)) begin
                cur_digit = digit_w[k];
            end
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] hi_zero;

    // hi_zero[k]: digit k and every digit above it are zero.
    always_comb begin
        logic acc;
        acc     = 1'b1;
        hi_zero = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            acc        = acc && (digit_w[k] == 4'd0);
            hi_zero[k] = acc;
        end
    end

    always_comb begin
        blank = 1'b0;
        for (int k = 1; k < NUM_DIGITS; k++) begin
            if (y_q == YW'(k)) begin
                blank = hi_zero[k];
            end
        end
    end
`else
    assign blank = 1'b0;
`endif

    assign an_d  = ~(NUM_DIGITS'(1) << y_q);
    assign seg_d = blank ? SEG_BLANK : seg_decode(cur_digit);

    always_ff @(posedge clk) begin
        if (rst) begin
            cpre_q <= '0;
            rpre_q <= '0;
            y_q    <= '0;
            wrap_q <= 1'b0;
            an_q   <= ~NUM_DIGITS'(1);
            seg_q  <= SEG_0;
        end else begin
            cpre_q <= cpre_d;
            rpre_q <= rpre_d;
            y_q    <= y_d;
            wrap_q <= wrap_d;
            an_q   <= an_d;
            seg_q  <= seg_d;
        end
    end

    assign bus.wrap = wrap_q;
    assign bus.Y    = y_q;
    assign bus.an   = an_q;
    assign bus.seg  = seg_q;

endmodule

// File: tb/tb_bcd_scan_counter.sv
// Scoreboard bench: a 2-digit counter (count/scan/glyph checks) and a 3-digit
// counter (non-power-of-2 scan index range).
module tb_bcd_scan_counter;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    bcd_scan_counter_if #(.NUM_DIGITS(2)) u_if2 ();
    bcd_scan_counter_if #(.NUM_DIGITS(3)) u_if3 ();

    bcd_scan_counter #(.NUM_DIGITS(2), .COUNT_DIV(2), .REFRESH_DIV(2)) u_dut2 (
        .clk (clk),
        .rst (rst),
        .bus (u_if2)
    );

    bcd_scan_counter #(.NUM_DIGITS(3), .COUNT_DIV(2), .REFRESH_DIV(2)) u_dut3 (
        .clk (clk),
        .rst (rst),
        .bus (u_if3)
    );

    typedef struct {
        logic [7:0] value;
        logic       wrap;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_errors = 0;
    int cur      = 0;
    int y_changes = 0;

    logic [6:0] glyph [10];

    initial begin
        glyph[0] = 7'b1000000; glyph[1] = 7'b1111001; glyph[2] = 7'b0100100;
        glyph[3] = 7'b0110000; glyph[4] = 7'b0011001; glyph[5] = 7'b0010010;
        glyph[6] = 7'b0000010; glyph[7] = 7'b1111000; glyph[8] = 7'b0000000;
        glyph[9] = 7'b0010000;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] to_bcd(input int d);
        return 8'(((d / 10) << 4) | (d % 10));
    endfunction

    function automatic logic [6:0] exp_glyph(input logic [7:0] v, input logic y);
        logic [3:0] d;
        d = y ? v[7:4] : v[3:0];
`ifdef LEADING_ZERO_BLANK_EN
        if (y && v[7:4] == 4'd0) return 7'b1111111;
`endif
        return glyph[d];
    endfunction

    task automatic push_exp(input logic [7:0] v, input logic w);
        exp_t e;
        e.value = v;
        e.wrap  = w;
        exp_q.push_back(e);
    endtask

    // Prescaler must be at 0 on entry; each step takes 4 enabled cycles.
    task automatic run_steps(input int n, input bit dir);
        int nxt;
        bit w;
        u_if2.up      = dir;
        u_if2.counten = 1'b1;
        for (int i = 0; i < n; i++) begin
            if (dir) begin
                nxt = (cur + 1) % 100;
                w   = (cur == 99);
            end else begin
                nxt = (cur + 99) % 100;
                w   = (cur == 0);
            end
            cur = nxt;
            push_exp(to_bcd(cur), w);
            repeat (4) @(negedge clk);
        end
        u_if2.counten = 1'b0;
    endtask

    // Value/wrap monitor: pops the scoreboard whenever the count changes.
    logic       armed = 1'b0;
    logic [7:0] v_prev;
    always @(posedge clk) begin
        #1;
        if (!armed) begin
            if (rst) begin
                armed  = 1'b1;
                v_prev = u_if2.value;
            end
        end else if (u_if2.value !== v_prev) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_change", 32'(u_if2.value), 32'(v_prev));
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("value", 32'(u_if2.value), 32'(e.value));
                chk("wrap", 32'(u_if2.wrap), 32'(e.wrap));
            end
            v_prev = u_if2.value;
        end else begin
            chk("wrap_idle", 32'(u_if2.wrap), 32'd0);
        end
    end

    // Scan monitor for the 2-digit unit: an/seg follow Y and value one cycle later.
    logic       s_armed = 1'b0;
    logic       y_prev;
    logic [7:0] sv_prev;
    int         interval = 0;
    bit         interval_ok = 1'b0;
    always @(posedge clk) begin
        #1;
        if (rst) begin
            if (s_armed) begin
                chk("rst_Y", 32'(u_if2.Y), 32'd0);
                chk("rst_an", 32'(u_if2.an), 32'b10);
                chk("rst_seg", 32'(u_if2.seg), 32'b1000000);
            end
            s_armed     = 1'b1;
            interval_ok = 1'b0;
            interval    = 0;
        end else if (s_armed) begin
            chk("an", 32'(u_if2.an), 32'(y_prev ? 2'b01 : 2'b10));
            chk("seg", 32'(u_if2.seg), 32'(exp_glyph(sv_prev, y_prev)));
            interval++;
            if (u_if2.Y !== y_prev) begin
                chk("Y_next", 32'(u_if2.Y), 32'(!y_prev));
                if (interval_ok) chk("Y_interval", 32'(interval), 32'd4);
                interval    = 0;
                interval_ok = 1'b1;
                y_changes++;
            end
        end
        y_prev  = u_if2.Y;
        sv_prev = u_if2.value;
    end

    // Scan monitor for the 3-digit unit.
    logic [1:0] y3_prev;
    logic       s3_armed = 1'b0;
    always @(posedge clk) begin
        #1;
        if (rst) begin
            s3_armed = 1'b1;
        end else if (s3_armed) begin
            logic [2:0] an_exp;
            case (y3_prev)
                2'd0:    an_exp = 3'b110;
                2'd1:    an_exp = 3'b101;
                default: an_exp = 3'b011;
            endcase
            chk("an3", 32'(u_if3.an), 32'(an_exp));
            if (u_if3.Y >= 2'd3) chk("Y3_range", 32'(u_if3.Y), 32'd2);
            if (u_if3.Y !== y3_prev)
                chk("Y3_next", 32'(u_if3.Y), 32'((y3_prev == 2'd2) ? 2'd0 : y3_prev + 2'd1));
        end
        y3_prev = u_if3.Y;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int yc0;
        u_if2.counten = 1'b0; u_if2.up = 1'b1; u_if2.clear = 1'b0;
        u_if3.counten = 1'b0; u_if3.up = 1'b1; u_if3.clear = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_value", 32'(u_if2.value), 32'h00);
        chk("reset_wrap", 32'(u_if2.wrap), 32'd0);
        chk("reset_Y", 32'(u_if2.Y), 32'd0);
        chk("reset_an", 32'(u_if2.an), 32'b10);
        chk("reset_seg", 32'(u_if2.seg), 32'b1000000);
        rst = 1'b0;
        repeat (12) @(negedge clk);

        run_steps(100, 1'b1);
        run_steps(2, 1'b0);
        run_steps(1, 1'b1);
        chk("at_99", 32'(u_if2.value), 32'h99);

        // Clear coincident with the step from 99: no wrap, value zeroed.
        u_if2.up = 1'b1;
        u_if2.counten = 1'b1;
        repeat (3) @(negedge clk);
        u_if2.clear = 1'b1;
        push_exp(8'h00, 1'b0);
        cur = 0;
        @(negedge clk);
        u_if2.clear = 1'b0;
        u_if2.counten = 1'b0;

        yc0 = y_changes;
        for (int i = 0; i < 100; i++) begin
            u_if2.up = i[0];
            @(negedge clk);
        end
        chk("hold_value", 32'(u_if2.value), 32'h00);
        chk("hold_scan", 32'(y_changes - yc0), 32'd25);

        // Prescaler holds while disabled: 2 + 2 enabled cycles make one step.
        u_if2.up = 1'b1;
        u_if2.counten = 1'b1;
        repeat (2) @(negedge clk);
        u_if2.counten = 1'b0;
        repeat (5) @(negedge clk);
        chk("split_hold", 32'(u_if2.value), 32'h00);
        cur = 1;
        push_exp(8'h01, 1'b0);
        u_if2.counten = 1'b1;
        repeat (2) @(negedge clk);
        u_if2.counten = 1'b0;
        repeat (3) @(negedge clk);

        // Reset overrides a coincident step and clear.
        u_if2.counten = 1'b1;
        repeat (3) @(negedge clk);
        push_exp(8'h00, 1'b0);
        cur = 0;
        rst = 1'b1;
        u_if2.clear = 1'b1;
        @(negedge clk);
        chk("rst_override_value", 32'(u_if2.value), 32'h00);
        chk("rst_override_wrap", 32'(u_if2.wrap), 32'd0);
        rst = 1'b0;
        u_if2.clear = 1'b0;
        u_if2.counten = 1'b0;
        @(negedge clk);

        run_steps(3, 1'b0);
        repeat (12) @(negedge clk);
        chk("final_value", 32'(u_if2.value), 32'h97);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
